huffman_bitpacker: RTL and testbench
====================================

Name: huffman_bitpacker

Overview:
- Downstream of the Huffman code generator; consumes its code table (code_valid, HC1..HC6, M1..M6).
- Replays the gray-level symbol stream through that table and packs variable-length codes MSB-first into bytes.
- Bytes leave on a valid/ready stream; a flush request pads the final partial byte and marks it last.

Parameters:
- ACC_W, 16, bit accumulator width; must be >= 16.
- PAD_BIT, 1'b0, value used to pad the final partial byte.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- code_valid  in  1  one-cycle pulse; HC1..HC6 and M1..M6 are valid in that cycle.
- HC1..HC6  in  8 each  code of symbol n, right-aligned.
- M1..M6  in  8 each  length mask of symbol n; code length = popcount(Mn).
- sym_valid  in  1  symbol present.
- sym_data  in  8  symbol value; 1..6 are legal.
- sym_ready  out  1  symbol accepted when sym_valid & sym_ready.
- flush  in  1  end-of-stream request.
- out_valid  out  1  packed byte available.
- out_data  out  8  packed byte; the first code bit is in bit 7.
- out_ready  in  1  sink accepts the byte.
- out_last  out  1  qualifies the final byte of the stream.
- busy  out  1  high in PACK or FLUSH.
- err  out  1  sticky illegal-symbol flag.
- done  out  1  one-cycle pulse at end of stream.

Behaviour:
- Reset (reset==0 at a clk edge): state LOAD_WAIT; acc=0, fill=0; table cleared; sym_ready, out_valid, out_data, out_last, busy, err and done all 0.
- LOAD_WAIT:
  - code_valid latches all 12 table bytes; next state PACK.
  - err clears on that load.
  - sym_valid and flush are ignored.
- PACK:
  - sym_ready = (fill <= 8), combinational.
  - On accept, look up len = popcount(Mn) and code = HCn[len-1:0]; HCn[len-1] is sent first.
  - Bits are placed at acc[ACC_W-1-fill -: len]; fill += len. They are visible on the next cycle.
  - Illegal symbol (sym_data 0 or >6, or Mn==0): the symbol is consumed, no bits are added, err<=1.
  - code_valid is ignored in PACK.
- Output:
  - out_valid = (fill >= 8), registered-state based.
  - out_data = acc[ACC_W-1 -: 8].
  - On out_valid & out_ready: acc <<= 8, fill -= 8.
- Pop and accept in the same cycle are both applied: the new bits go at position (fill-8).
- Latency: a symbol accepted at cycle t can complete a byte with out_valid at t+1.
- Backpressure: out_ready low holds out_data stable. fill saturates at <= 15, and sym_ready drops once fill > 8.
- flush is sampled in PACK only. A symbol handshaken in the same cycle is included. Next state is FLUSH, and sym_ready is 0 from the following cycle.
- FLUSH:
  - If fill==0, go straight to DONE; no byte, no out_last.
  - Else emit full bytes normally. When 0 < fill <= 8, the remaining bits are padded with PAD_BIT to 8, out_valid=1 and out_last=1.
  - On the last handshake, go to DONE.
- DONE: done=1 for exactly one cycle; then LOAD_WAIT. A new table is required for the next stream.
- Reset mid-stream discards all pending bits; no partial byte is emitted.

Optional Feature:
- Macro: HUFFMAN_BITPACKER_BITCNT_EN.
- Defined: extra output bit_count[15:0] counts valid code bits accepted since the last table load, excluding pad bits. It saturates at 16'hFFFF, resets to 0 and clears on code_valid.
- Undefined: no bit_count port and no counter logic.

Test Plan:
- Table HC1..6=00,02,06,0E,1E,1F and M1..6=01,03,07,0F,1F,1F. Symbols 3,2,4,1, then flush, out_ready=1 -> bytes 0xD7 then 0x00 with out_last=1, then a done pulse; err=0.
- Same table, symbols 5,6, flush -> 0xF7 then 0xC0 (out_last=1).
- out_ready=0, symbol 6 offered continuously:
  - 2 accepted (fill 10), then sym_ready=0 while out_data=0xFF holds.
  - Raising out_ready pops 0xFF, and sym_ready returns.
- Symbols 0, 7 and 3, then flush -> err=1 after the first symbol. Only "110" is packed: single byte 0xC0 with out_last=1.
- Flush right after the table load -> no out_valid; done pulses 1 cycle later; state returns to LOAD_WAIT; code_valid reloads.
- reset=0 while fill=5 in PACK -> all outputs 0 next cycle. Symbols are ignored until a new code_valid.

Source files
------------

// File: rtl/huffman_bitpacker_if.sv
// ============================================================================
// Module   : huffman_bitpacker_if
// Brief    : Code-table load, symbol stream and byte stream bundle for the
//            Huffman bit packer. bit_count exists only with
//            HUFFMAN_BITPACKER_BITCNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface huffman_bitpacker_if;
    logic       code_valid;
    logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0] M1, M2, M3, M4, M5, M6;
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       sym_ready;
    logic       flush;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       err;
    logic       done;
`ifdef HUFFMAN_BITPACKER_BITCNT_EN
    logic [15:0] bit_count;
`endif

    modport master (
        output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
        output M1, M2, M3, M4, M5, M6,
        output sym_valid, sym_data, flush, out_ready,
        input  sym_ready, out_valid, out_data, out_last, busy, err, done
`ifdef HUFFMAN_BITPACKER_BITCNT_EN
        , input bit_count
`endif
    );

    modport slave (
        input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
        input  M1, M2, M3, M4, M5, M6,
        input  sym_valid, sym_data, flush, out_ready,
        output sym_ready, out_valid, out_data, out_last, busy, err, done
`ifdef HUFFMAN_BITPACKER_BITCNT_EN
        , output bit_count
`endif
    );
endinterface

`default_nettype wire

// File: rtl/huffman_bitpacker.sv
// ============================================================================
// Module   : huffman_bitpacker
// Brief    : Packs Huffman codes MSB-first into bytes on a valid/ready stream.
//            Optional bit counter: HUFFMAN_BITPACKER_BITCNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module huffman_bitpacker #(
    parameter int   ACC_W   = 16,
    parameter logic PAD_BIT = 1'b0
) (
    input wire             clk,
    input wire             reset,
    huffman_bitpacker_if.slave bus
);
    localparam int FILL_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        S_LOAD_WAIT = 2'd0,
        S_PACK      = 2'd1,
        S_FLUSH     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          hc_q [0:5];
    logic [7:0]          m_q  [0:5];

    logic                w_sym_ready, w_accept, w_out_valid, w_pop, w_last;
    logic                w_in_range, w_legal;
    logic [2:0]          w_idx;
    logic [7:0]          w_m, w_hc, w_code, w_code_al, w_pad;
    logic [3:0]          w_len;
    logic [FILL_W-1:0]   w_fill_base;
    logic [ACC_W-1:0]    w_ins;
`ifdef HUFFMAN_BITPACKER_BITCNT_EN
    logic [15:0]         bit_count_q, bit_count_d;
    logic [16:0]         w_bc_sum;
`endif

    always_comb begin
        w_sym_ready = (state_q == S_PACK) && (fill_q <= FILL_W'(8));
        w_accept    = bus.sym_valid && w_sym_ready;
        w_out_valid = ((state_q == S_PACK) && (fill_q >= FILL_W'(8))) ||
                      ((state_q == S_FLUSH) && (fill_q != '0));
        w_last      = (state_q == S_FLUSH) && (fill_q != '0) && (fill_q <= FILL_W'(8));
        w_pop       = w_out_valid && bus.out_ready;
        w_pad       = (w_last && PAD_BIT) ? (8'hFF >> fill_q) : 8'h00;

        w_in_range  = (bus.sym_data >= 8'd1) && (bus.sym_data <= 8'd6);
        w_idx       = w_in_range ? (bus.sym_data[2:0] - 3'd1) : 3'd0;
        w_m         = w_in_range ? m_q[w_idx] : 8'h00;
        w_hc        = w_in_range ? hc_q[w_idx] : 8'h00;
        w_len       = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_len = w_len + {3'b000, w_m[i]};
        end
        w_legal     = w_in_range && (w_m != 8'h00);
        w_code      = w_hc & ~(8'hFF << w_len);
        // Left-align the code so its first bit lands at the accumulator write pointer.
        w_code_al   = w_code << (4'd8 - w_len);
        w_fill_base = w_pop ? (fill_q - FILL_W'(8)) : fill_q;
        w_ins       = {w_code_al, {(ACC_W-8){1'b0}}} >> w_fill_base;

        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        err_d   = err_q;

        case (state_q)
            S_LOAD_WAIT: begin
                if (bus.code_valid) begin
                    state_d = S_PACK;
                    err_d   = 1'b0;
                    acc_d   = '0;
                    fill_d  = '0;
                end
            end
            S_PACK: begin
                if (w_pop) begin
                    acc_d  = acc_q << 8;
                    fill_d = fill_q - FILL_W'(8);
                end
                if (w_accept) begin
                    if (w_legal) begin
                        acc_d  = acc_d | w_ins;
                        fill_d = fill_d + FILL_W'(w_len);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (bus.flush) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fill_q == '0) begin
                    state_d = S_DONE;
                end else if (w_pop) begin
                    if (w_last) begin
                        acc_d   = '0;
                        fill_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        acc_d  = acc_q << 8;
                        fill_d = fill_q - FILL_W'(8);
                    end
                end
            end
            default: state_d = S_LOAD_WAIT;
        endcase

        busy_d = (state_d == S_PACK) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);

`ifdef HUFFMAN_BITPACKER_BITCNT_EN
        w_bc_sum    = {1'b0, bit_count_q} + 17'(w_len);
        bit_count_d = bit_count_q;
        if ((state_q == S_LOAD_WAIT) && bus.code_valid) begin
            bit_count_d = 16'h0000;
        end else if (w_accept && w_legal) begin
            bit_count_d = w_bc_sum[16] ? 16'hFFFF : w_bc_sum[15:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_LOAD_WAIT;
            acc_q   <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                hc_q[i] <= 8'h00;
                m_q[i]  <= 8'h00;
            end
`ifdef HUFFMAN_BITPACKER_BITCNT_EN
            bit_count_q <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if ((state_q == S_LOAD_WAIT) && bus.code_valid) begin
                hc_q[0] <= bus.HC1;  m_q[0] <= bus.M1;
                hc_q[1] <= bus.HC2;  m_q[1] <= bus.M2;
                hc_q[2] <= bus.HC3;  m_q[2] <= bus.M3;
                hc_q[3] <= bus.HC4;  m_q[3] <= bus.M4;
                hc_q[4] <= bus.HC5;  m_q[4] <= bus.M5;
                hc_q[5] <= bus.HC6;  m_q[5] <= bus.M6;
            end
`ifdef HUFFMAN_BITPACKER_BITCNT_EN
            bit_count_q <= bit_count_d;
`endif
        end
    end

    assign bus.sym_ready = w_sym_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = acc_q[ACC_W-1 -: 8] | w_pad;
    assign bus.out_last  = w_last;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.done      = done_q;
`ifdef HUFFMAN_BITPACKER_BITCNT_EN
    assign bus.bit_count = bit_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_huffman_bitpacker.sv
// ============================================================================
// Module   : tb_huffman_bitpacker
// Brief    : Directed, table-driven bench for huffman_bitpacker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_huffman_bitpacker;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    huffman_bitpacker_if bus ();

    huffman_bitpacker #(.ACC_W(16), .PAD_BIT(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  nsym;
        logic [31:0] syms;    // symbol i at [8*i +: 8]
        logic [1:0]  nbytes;
        logic [23:0] bytes;   // byte i at [8*i +: 8]
        logic        err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_table();
        @(negedge clk);
        bus.code_valid = 1'b1;
        @(negedge clk);
        bus.code_valid = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        logic [7:0] got_b [0:3];
        logic       got_l [0:3];
        int         nb;
        bit         seen_done;
        logic       err_at_done;
        nb = 0;
        seen_done = 1'b0;
        err_at_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got_b[k] = 8'h00;
            got_l[k] = 1'b0;
        end
        load_table();
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < int'(v.nsym); i++) begin
                    int guard;
                    guard = 0;
                    bus.sym_valid = 1'b1;
                    bus.sym_data  = v.syms[8*i +: 8];
                    while (!bus.sym_ready && guard < 20) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (guard >= 20) check($sformatf("v%0d sym_ready timeout", n), 32'd1, 32'd0);
                    bus.flush = (i == int'(v.nsym) - 1);
                    @(negedge clk);
                    bus.sym_valid = 1'b0;
                    bus.flush     = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 60 && !seen_done; c++) begin
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) begin
                        if (nb < 4) begin
                            got_b[nb] = bus.out_data;
                            got_l[nb] = bus.out_last;
                        end
                        nb++;
                    end
                    if (bus.done) begin
                        seen_done = 1'b1;
                        err_at_done = bus.err;
                    end
                end
            end
        join
        check($sformatf("v%0d done seen", n), 32'(seen_done), 32'd1);
        check($sformatf("v%0d byte count", n), 32'(nb), 32'(v.nbytes));
        for (int k = 0; k < int'(v.nbytes); k++) begin
            check($sformatf("v%0d byte%0d", n, k), 32'(got_b[k]), 32'(v.bytes[8*k +: 8]));
            check($sformatf("v%0d last%0d", n, k), 32'(got_l[k]), 32'(k == int'(v.nbytes) - 1));
        end
        check($sformatf("v%0d err", n), 32'(err_at_done), 32'(v.err));
    endtask

    vec_t vecs [0:4];
    int   acc_cnt;

    initial begin
        bus.code_valid = 1'b0;
        bus.HC1 = 8'h00; bus.HC2 = 8'h02; bus.HC3 = 8'h06;
        bus.HC4 = 8'h0E; bus.HC5 = 8'h1E; bus.HC6 = 8'h1F;
        bus.M1  = 8'h01; bus.M2  = 8'h03; bus.M3  = 8'h07;
        bus.M4  = 8'h0F; bus.M5  = 8'h1F; bus.M6  = 8'h1F;
        bus.sym_valid = 1'b0;
        bus.sym_data  = 8'h00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{nsym: 3'd4, syms: 32'h01040203, nbytes: 2'd2, bytes: 24'h0000D7, err: 1'b0};
        vecs[1] = '{nsym: 3'd2, syms: 32'h00000605, nbytes: 2'd2, bytes: 24'h00C0F7, err: 1'b0};
        vecs[2] = '{nsym: 3'd3, syms: 32'h00030700, nbytes: 2'd1, bytes: 24'h0000C0, err: 1'b1};
        vecs[3] = '{nsym: 3'd4, syms: 32'h06060606, nbytes: 2'd3, bytes: 24'hF0FFFF, err: 1'b0};
        vecs[4] = '{nsym: 3'd4, syms: 32'h02020202, nbytes: 2'd1, bytes: 24'h0000AA, err: 1'b0};

        repeat (3) @(negedge clk);
        check("reset outputs", {bus.sym_ready, bus.out_valid, bus.out_last, bus.busy,
                                bus.err, bus.done, bus.out_data}, 32'd0);
        reset = 1'b1;

        // Symbols and flush before any table load must be ignored.
        bus.sym_valid = 1'b1; bus.sym_data = 8'd3; bus.flush = 1'b1;
        repeat (2) @(negedge clk);
        check("idle sym_ready", 32'(bus.sym_ready), 32'd0);
        check("idle busy/done", {bus.busy, bus.done, bus.out_valid}, 32'd0);
        bus.sym_valid = 1'b0; bus.flush = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Backpressure: two length-5 codes fill 10 bits, then the input stalls.
        load_table();
        bus.out_ready = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = 8'd6;
        acc_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                check($sformatf("bp c%0d sym_ready", c), 32'(bus.sym_ready), 32'd0);
                check($sformatf("bp c%0d out_data", c), 32'(bus.out_data), 32'hFF);
                check($sformatf("bp c%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            end
            if (bus.sym_ready) acc_cnt++;
            @(negedge clk);
        end
        check("bp accepted", 32'(acc_cnt), 32'd2);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp sym_ready back", 32'(bus.sym_ready), 32'd1);
        check("bp out_valid after pop", 32'(bus.out_valid), 32'd0);
        bus.sym_valid = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("bp flush byte", {bus.out_valid, bus.out_last, bus.out_data}, {22'd0, 1'b1, 1'b1, 8'hC0});
        check("bp flush sym_ready", 32'(bus.sym_ready), 32'd0);
        @(negedge clk);
        check("bp done", 32'(bus.done), 32'd1);

        // Flush straight after a load: no byte, done two cycles after the flush.
        load_table();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("ef flush state", {bus.out_valid, bus.busy, bus.done}, 32'b010);
        @(negedge clk);
        check("ef done", {bus.out_valid, bus.busy, bus.done}, 32'b001);
        @(negedge clk);
        check("ef back to wait", {bus.sym_ready, bus.busy, bus.done}, 32'd0);
        load_table();
        check("ef reload", {bus.sym_ready, bus.busy}, 32'b11);

        // Reset with 5 pending bits discards them.
        bus.sym_valid = 1'b1; bus.sym_data = 8'd5;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        check("rst pre fill5", {bus.out_valid, bus.sym_ready}, 32'b01);
        reset = 1'b0;
        @(negedge clk);
        check("rst mid outputs", {bus.sym_ready, bus.out_valid, bus.out_last, bus.busy,
                                  bus.err, bus.done, bus.out_data}, 32'd0);
        reset = 1'b1;
        bus.sym_valid = 1'b1; bus.sym_data = 8'd3;
        repeat (3) @(negedge clk);
        check("rst ignores syms", {bus.sym_ready, bus.out_valid, bus.busy}, 32'd0);
        bus.sym_valid = 1'b0;
        run_vec(5, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
